// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared constants and helpers for the scoreboarded register file.
//   DW_DEF / AW_DEF / ENTRY_DEF : default data width, address width, entry count
//   CNT_W_DEF                   : width of a popcount over 2^AW_DEF entries (AW_DEF+1)
//   addr_writable()             : true when an address may be written or marked pending
package regfile_pkg;

  localparam int DW_DEF    = 32;
  localparam int AW_DEF    = 5;
  localparam int ENTRY_DEF = 32;
  localparam int CNT_W_DEF = AW_DEF + 1;

  // An address is writable when it names a real entry and is not the
  // hardwired zero register.
  function automatic logic addr_writable(input int addr, input int entry, input logic zero_r0);
    return (addr < entry) && !(zero_r0 && (addr == 0));
  endfunction

endpackage

// File: rtl/regfile_sb_score.sv
// regfile_sb_score -- pending-bit scoreboard for the register file.
//   CLK, RSTN (sync, active-low)
//   WEN/WA   : write strobe (active-low) and address; a write clears pend[WA]
//   SEN/SA   : set strobe (active-low) and address; a set marks pend[SA]
//   pend     : per-entry pending vector
//   BUSY_CNT : registered count of pending entries
module regfile_sb_score
  import regfile_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int ENTRY   = ENTRY_DEF,
  parameter int ZERO_R0 = 1
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             WEN,
  input  logic [AW-1:0]    WA,
  input  logic             SEN,
  input  logic [AW-1:0]    SA,
  output logic [ENTRY-1:0] pend,
  output logic [AW:0]      BUSY_CNT
);

  localparam int CW = AW + 1;

  logic             set_v;
  logic             clr_v;
  logic             sa_pend;
  logic             wa_pend;
  logic             inc;
  logic             dec;
  logic [ENTRY-1:0] pend_nxt;

  assign set_v = RSTN && !SEN && addr_writable(int'(SA), ENTRY, ZERO_R0 != 0);
  assign clr_v = RSTN && !WEN && addr_writable(int'(WA), ENTRY, ZERO_R0 != 0);

  // NOTE: combinational blocks use blocking '=' and give every output a
  // default first, so later statements override earlier ones and no latch
  // is inferred.
  always_comb begin
    pend_nxt = pend;
    sa_pend  = 1'b0;
    wa_pend  = 1'b0;
    for (int i = 0; i < ENTRY; i++) begin
      if (SA == AW'(i)) sa_pend = pend[i];
      if (WA == AW'(i)) wa_pend = pend[i];
      if (clr_v && (WA == AW'(i))) pend_nxt[i] = 1'b0;
      // Set is applied after clear: a new producer wins over a retiring one.
      if (set_v && (SA == AW'(i))) pend_nxt[i] = 1'b1;
    end
  end

  // Incremental popcount: a same-address set+clear leaves the bit set, so
  // only the set side may count in that case.
  assign inc = set_v && !sa_pend;
  assign dec = clr_v && wa_pend && !(set_v && (SA == WA));

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      pend     <= '0;
      BUSY_CNT <= '0;
    end else begin
      pend     <= pend_nxt;
      BUSY_CNT <= BUSY_CNT + CW'(inc) - CW'(dec);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb -- multi-read-port register file with write bypass and an
// operand-ready scoreboard.
//   CLK, RSTN (sync, active-low)
//   WEN/WA/DI : write port (WEN active-low)
//   SEN/SA    : scoreboard set (active-low), marks SA pending
//   RA        : NRP packed read addresses, port p at [p*AW +: AW]
//   DOUT      : NRP packed read data,      port p at [p*DW +: DW]
//   RDY       : per-port operand ready (address not pending)
//   BUSY_CNT  : number of pending registers (registered)
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter int ENTRY   = ENTRY_DEF,
  parameter int NRP     = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              WEN,
  input  logic [AW-1:0]     WA,
  input  logic [DW-1:0]     DI,
  input  logic              SEN,
  input  logic [AW-1:0]     SA,
  input  logic [NRP*AW-1:0] RA,
  output logic [NRP*DW-1:0] DOUT,
  output logic [NRP-1:0]    RDY,
  output logic [AW:0]       BUSY_CNT
);

  logic [DW-1:0]    ram [ENTRY];
  logic [ENTRY-1:0] pend;
  logic             wr_v;

  // Write strobe is also the bypass qualifier: bypass is off in reset and
  // for non-writable addresses.
  assign wr_v = RSTN && !WEN && addr_writable(int'(WA), ENTRY, ZERO_R0 != 0);

  regfile_sb_score #(
    .AW      (AW),
    .ENTRY   (ENTRY),
    .ZERO_R0 (ZERO_R0)
  ) u_score (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .WEN      (WEN),
    .WA       (WA),
    .SEN      (SEN),
    .SA       (SA),
    .pend     (pend),
    .BUSY_CNT (BUSY_CNT)
  );

  // NOTE: the array is cleared on reset because reads of never-written
  // registers must return zero; this rules out a plain RAM macro.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      for (int i = 0; i < ENTRY; i++) ram[i] <= '0;
    end else if (wr_v) begin
      for (int i = 0; i < ENTRY; i++) begin
        if (WA == AW'(i)) ram[i] <= DI;
      end
    end
  end

  for (genvar p = 0; p < NRP; p++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic          rdy;

    assign ra = RA[p*AW +: AW];

    // Priority low to high: array lookup, zero register, write bypass.
    // Addresses beyond ENTRY match no entry and keep the 0 / ready default.
    always_comb begin
      rd  = '0;
      rdy = 1'b1;
      for (int i = 0; i < ENTRY; i++) begin
        if (ra == AW'(i)) begin
          rd  = ram[i];
          rdy = !pend[i];
        end
      end
      if ((ZERO_R0 != 0) && (ra == '0)) begin
        rd  = '0;
        rdy = 1'b1;
      end
      if (wr_v && (ra == WA)) begin
        rd  = DI;
        rdy = 1'b1;
      end
    end

    assign DOUT[p*DW +: DW] = rd;
    assign RDY[p]           = rdy;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb -- directed scoreboard bench for regfile_sb (default parameters).
// Stimulus drives inputs 1 ns after each rising edge and queues expected
// outputs; a monitor on the falling edge pops and compares them.
module tb_regfile_sb;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        WEN;
  logic [4:0]  WA;
  logic [31:0] DI;
  logic        SEN;
  logic [4:0]  SA;
  logic [9:0]  RA;
  logic [63:0] DOUT;
  logic [1:0]  RDY;
  logic [5:0]  BUSY_CNT;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    bit          is_busy;
    int          port;
    logic [31:0] val;
    logic        rdy;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  regfile_sb dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .WEN      (WEN),
    .WA       (WA),
    .DI       (DI),
    .SEN      (SEN),
    .SA       (SA),
    .RA       (RA),
    .DOUT     (DOUT),
    .RDY      (RDY),
    .BUSY_CNT (BUSY_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic exp_port(input int p, input logic [31:0] v, input logic r, input string n);
    exp_t e;
    e.is_busy = 1'b0;
    e.port    = p;
    e.val     = v;
    e.rdy     = r;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic exp_busy(input logic [5:0] b, input string n);
    exp_t e;
    e.is_busy = 1'b1;
    e.port    = 0;
    e.val     = {26'd0, b};
    e.rdy     = 1'b0;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic drive(input logic rstn, input logic wen, input logic [4:0] wa,
                       input logic [31:0] di, input logic sen, input logic [4:0] sa,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    RSTN = rstn;
    WEN  = wen;
    WA   = wa;
    DI   = di;
    SEN  = sen;
    SA   = sa;
    RA   = {ra1, ra0};
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: everything queued since the last rising edge describes the
  // combinational/registered outputs visible now.
  exp_t  m_e;
  string m_n;
  always @(negedge CLK) begin
    while (exp_q.size() != 0) begin
      m_e = exp_q.pop_front();
      m_n = name_q.pop_front();
      if (m_e.is_busy) begin
        check({m_n, ".busy"}, {26'd0, BUSY_CNT}, m_e.val);
      end else begin
        check({m_n, ".dout"}, DOUT[m_e.port*32 +: 32], m_e.val);
        check({m_n, ".rdy"}, {31'd0, RDY[m_e.port]}, {31'd0, m_e.rdy});
      end
    end
  end

  initial begin
    // Reset for one edge, then every address reads zero and ready.
    drive(1'b0, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0);
    step();
    for (int a = 0; a < 32; a++) begin
      drive(1'b1, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 5'(a), 5'(31 - a));
      exp_port(0, 32'd0, 1'b1, "rst.p0");
      exp_port(1, 32'd0, 1'b1, "rst.p1");
      exp_busy(6'd0, "rst");
      step();
    end

    // Write with same-cycle bypass on both ports, then plain read.
    drive(1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 5'd0, 5'd5, 5'd5);
    exp_port(0, 32'hDEADBEEF, 1'b1, "byp.p0");
    exp_port(1, 32'hDEADBEEF, 1'b1, "byp.p1");
    step();
    drive(1'b1, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 5'd5, 5'd5);
    exp_port(0, 32'hDEADBEEF, 1'b1, "wr.p0");
    exp_port(1, 32'hDEADBEEF, 1'b1, "wr.p1");
    step();

    // Scoreboard set of 7, then a write to 7 retires it.
    drive(1'b1, 1'b1, 5'd0, 32'd0, 1'b0, 5'd7, 5'd0, 5'd7);
    exp_busy(6'd0, "set7.pre");
    step();
    drive(1'b1, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd7);
    exp_port(1, 32'd0, 1'b0, "pend7");
    exp_busy(6'd1, "pend7");
    step();
    drive(1'b1, 1'b0, 5'd7, 32'h11, 1'b1, 5'd0, 5'd0, 5'd7);
    exp_port(1, 32'h11, 1'b1, "clr7.byp");
    exp_busy(6'd1, "clr7.pre");
    step();
    drive(1'b1, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd7);
    exp_port(1, 32'h11, 1'b1, "clr7.post");
    exp_busy(6'd0, "clr7.post");
    step();

    // Collision on 3: data written, but the new producer keeps it pending.
    drive(1'b1, 1'b0, 5'd3, 32'h22, 1'b0, 5'd3, 5'd3, 5'd0);
    exp_port(0, 32'h22, 1'b1, "coll.byp");
    step();
    drive(1'b1, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 5'd3, 5'd0);
    exp_port(0, 32'h22, 1'b0, "coll.post");
    exp_busy(6'd1, "coll.post");
    step();

    // Zero register ignores write and set.
    drive(1'b1, 1'b0, 5'd0, 32'hFFFF, 1'b0, 5'd0, 5'd0, 5'd0);
    exp_port(0, 32'd0, 1'b1, "r0.same.p0");
    exp_port(1, 32'd0, 1'b1, "r0.same.p1");
    exp_busy(6'd1, "r0.same");
    step();
    drive(1'b1, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0);
    exp_port(0, 32'd0, 1'b1, "r0.post");
    exp_busy(6'd1, "r0.post");
    step();

    // Re-set of already pending 3 leaves the count alone.
    drive(1'b1, 1'b1, 5'd0, 32'd0, 1'b0, 5'd3, 5'd3, 5'd0);
    exp_port(0, 32'h22, 1'b0, "reset3");
    step();
    // Set 9 while clearing 3: net zero.
    drive(1'b1, 1'b0, 5'd3, 32'h33, 1'b0, 5'd9, 5'd3, 5'd9);
    exp_busy(6'd1, "reset3.post");
    exp_port(0, 32'h33, 1'b1, "swap.byp");
    exp_port(1, 32'd0, 1'b1, "swap.p1");
    step();
    drive(1'b1, 1'b1, 5'd0, 32'd0, 1'b0, 5'd10, 5'd3, 5'd9);
    exp_port(0, 32'h33, 1'b1, "swap.p0");
    exp_port(1, 32'd0, 1'b0, "swap.pend9");
    exp_busy(6'd1, "swap.post");
    step();
    drive(1'b1, 1'b1, 5'd0, 32'd0, 1'b0, 5'd12, 5'd0, 5'd10);
    exp_port(1, 32'd0, 1'b0, "pend10");
    exp_busy(6'd2, "set10.post");
    step();
    drive(1'b1, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd12);
    exp_port(1, 32'd0, 1'b0, "pend12");
    exp_busy(6'd3, "three.pending");
    step();

    // Reset mid-operation with a set and a write in the same cycle: no
    // bypass, outputs reflect stored state until the edge clears it.
    drive(1'b0, 1'b0, 5'd5, 32'h55, 1'b0, 5'd9, 5'd5, 5'd10);
    exp_port(0, 32'hDEADBEEF, 1'b1, "inrst.p0");
    exp_port(1, 32'd0, 1'b0, "inrst.p1");
    exp_busy(6'd3, "inrst");
    step();
    drive(1'b1, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 5'd5, 5'd9);
    exp_port(0, 32'd0, 1'b1, "postrst.r5");
    exp_port(1, 32'd0, 1'b1, "postrst.r9");
    exp_busy(6'd0, "postrst");
    step();
    drive(1'b1, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 5'd10, 5'd12);
    exp_port(0, 32'd0, 1'b1, "postrst.r10");
    exp_port(1, 32'd0, 1'b1, "postrst.r12");
    step();

    // Let the monitor drain; anything left over is a missed comparison.
    repeat (2) @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
